if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- IF/ID pipeline stage of the RV32I pipelined CPU.
- Registers fetched PC/instruction pairs through a 2-entry skid buffer with valid/ready handshake, flush and stall.
- Presents the decode stage with the registered instruction and pre-sliced immediate fields (iimm, simm, bimm, uimm, jimm) that feed the immediate extender directly.
- Also presents register indices and opcode/funct fields.

Parameters:
- XLEN, 32, width of PC and instruction.
- NOP_INSTR, 32'h00000013, instruction word presented when stage output is invalid (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- if_valid  in  1  fetch presents a valid pc/instr.
- if_pc  in  XLEN  fetch PC.
- if_instr  in  XLEN  fetched instruction word.
- if_ready  out  1  stage can accept; registered, equals !skid_valid.
- flush  in  1  discard all held and incoming instructions (taken branch/jump from EX).
- id_ready  in  1  decode consumes head this cycle (low = load-use stall).
- id_valid  out  1  head entry valid.
- id_pc  out  XLEN  head PC.
- id_instr  out  XLEN  head instruction; NOP_INSTR when !id_valid.
- id_opcode  out  7  id_instr[6:0].
- id_rd, id_rs1, id_rs2  out  5 each  id_instr[11:7], [19:15], [24:20].
- id_funct3  out  3  id_instr[14:12].
- id_funct7  out  7  id_instr[31:25].
- id_iimm  out  12  id_instr[31:20].
- id_simm  out  12  {id_instr[31:25], id_instr[11:7]}.
- id_bimm  out  12  {id_instr[31], id_instr[7], id_instr[30:25], id_instr[11:8]}.
- id_uimm  out  20  id_instr[31:12].
- id_jimm  out  20  id_instr[31:12], raw; the extender reorders it.

Behaviour:
- State: head {valid, pc, instr}, skid {valid, pc, instr}.
- Outputs come straight from head registers plus combinational slicing; no combinational path from if_* to id_*.
- Reset (rst=1 at edge):
  - head.valid=0, skid.valid=0, so id_valid=0 and if_ready=1.
  - id_pc=0, id_instr=NOP_INSTR, so all slices decode from NOP.
- Definitions: acc = if_valid & if_ready; con = id_valid & id_ready.
- Flush has highest priority below rst:
  - Next state: head and skid invalid, head.instr=NOP_INSTR, head.pc unchanged.
  - The instruction offered in the flush cycle is dropped even if acc=1.
- Otherwise the next state is given by the occupancy case:
  - Empty (head invalid): acc loads head. id_ready is ignored.
  - Head only, con & acc: head <= incoming (1-cycle throughput).
  - Head only, con & !acc: head invalid, instr <= NOP_INSTR.
  - Head only, !con & acc: skid <= incoming, so if_ready=0 next cycle.
  - Head only, !con & !acc: hold.
  - Full (skid valid, if_ready=0): con moves head <= skid and skid invalid. !con holds.
- Ordering: program order is always preserved (skid entry is never bypassed).
- Latency: 1 cycle from acc to id_valid when empty.
- Reset or flush mid-stall discards both entries regardless of id_ready.
- An invalid head always drives NOP_INSTR, never stale bits.

Optional Feature:
- Macro: IFID_ILLEGAL_CHK_EN.
- Defined:
  - Extra output id_illegal (1 bit).
  - High when id_valid and either id_opcode[1:0]!=2'b11 or id_opcode is not an RV32I major opcode (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM).
  - 0 when !id_valid; 0 after reset.
- Undefined: port absent; no logic.

Decomposition:
- Shared package/defines (extend existing encode header):
  - RV32I opcode constants.
  - NOP_INSTR value.
  - Field bit positions.
- Sub-module instr_field_slicer (combinational): instruction -> opcode/rd/rs1/rs2/funct3/funct7 and iimm/simm/bimm/uimm/jimm. It is reusable by later stages.

Test Plan:
- Reset then idle -> id_valid=0, id_instr=32'h00000013, id_iimm=12'h000, if_ready=1.
- Stream 3 instrs with id_ready=1 (pc 0,4,8) -> each appears 1 cycle after accept, back-to-back, if_ready stays 1.
- Load 32'hFE010EE3 (beq, neg offset) -> id_bimm=12'hFEE, id_simm=12'hFFD, id_rs1=2, id_rs2=0.
- Load 32'h800000EF (jal) -> id_jimm=20'h80000, id_rd=1.
- Stall: id_ready=0 while sending pc 0x10, 0x14 -> head holds 0x10, skid takes 0x14, if_ready=0; offer of 0x18 not accepted. Release id_ready -> 0x10, 0x14, then 0x18 in order; 0x18 accepted after if_ready returns 1.
- Full buffer + flush=1 with if_valid=1 pc 0x20 -> next cycle id_valid=0, if_ready=1, 0x20 never appears.
- With IFID_ILLEGAL_CHK_EN: instr 32'h00000000 -> id_illegal=1; NOP -> 0.

Source files
------------

// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF/ID stage: RV32I major opcodes, the NOP word,
// instruction field positions, buffer occupancy encoding and an opcode
// legality helper.
package if_id_stage_pkg;

  localparam int XLEN_DEF = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Field bit positions (LSB of each field)
  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

  // Occupancy of the 2-entry buffer as {head valid, skid valid}
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_BAD   = 2'b01,
    OCC_HEAD  = 2'b10,
    OCC_FULL  = 2'b11
  } occ_e;

  // True when opc is one of the RV32I major opcodes (implies opc[1:0]==2'b11)
  function automatic logic is_rv32i_opcode(input logic [6:0] opc);
    logic legal;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/if_id_stage_instr_field_slicer.sv
// Combinational instruction field slicer: splits an RV32I instruction into
// register indices, opcode/funct fields and raw immediate fields. Reusable by
// later pipeline stages; the immediate extender reorders/sign-extends.
module instr_field_slicer
  import if_id_stage_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [6:0]  opcode_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [11:0] iimm_o,
  output logic [11:0] simm_o,
  output logic [11:0] bimm_o,
  output logic [19:0] uimm_o,
  output logic [19:0] jimm_o
);

  assign opcode_o = instr_i[OPCODE_LSB +: 7];
  assign rd_o     = instr_i[RD_LSB     +: 5];
  assign funct3_o = instr_i[FUNCT3_LSB +: 3];
  assign rs1_o    = instr_i[RS1_LSB    +: 5];
  assign rs2_o    = instr_i[RS2_LSB    +: 5];
  assign funct7_o = instr_i[FUNCT7_LSB +: 7];

  assign iimm_o = instr_i[31:20];
  assign simm_o = {instr_i[31:25], instr_i[11:7]};
  assign bimm_o = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8]};
  assign uimm_o = instr_i[31:12];
  // Raw J-type bits; bit reordering happens in the extender.
  assign jimm_o = instr_i[31:12];

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: 2-entry skid buffer (head + skid) between fetch and
// decode with valid/ready handshake, flush and stall. Decode sees only head
// registers plus combinational field slicing.
// Optional: define IFID_ILLEGAL_CHK_EN to add the id_illegal output.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int          XLEN      = XLEN_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_instr,
  output logic            if_ready,
  input  logic            flush,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic [6:0]      id_opcode,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7,
  output logic [11:0]     id_iimm,
  output logic [11:0]     id_simm,
  output logic [11:0]     id_bimm,
  output logic [19:0]     id_uimm,
  output logic [19:0]     id_jimm
`ifdef IFID_ILLEGAL_CHK_EN
  ,
  output logic            id_illegal
`endif
);

  logic            head_valid_q, head_valid_d;
  logic [XLEN-1:0] head_pc_q,    head_pc_d;
  logic [XLEN-1:0] head_instr_q, head_instr_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_pc_q,    skid_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic            acc;
  logic            con;
  occ_e            occ;

  assign if_ready = ~skid_valid_q;
  assign acc      = if_valid & if_ready;
  assign con      = head_valid_q & id_ready;
  assign occ      = occ_e'({head_valid_q, skid_valid_q});

  // Next-state of head/skid: flush first, then per-occupancy handshake rules
  always_comb begin
    head_valid_d = head_valid_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (flush) begin
      // Drop both entries and the incoming offer; head PC is kept.
      head_valid_d = 1'b0;
      head_instr_d = NOP_INSTR;
      skid_valid_d = 1'b0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (acc) begin
            head_valid_d = 1'b1;
            head_pc_d    = if_pc;
            head_instr_d = if_instr;
          end else begin
            head_instr_d = NOP_INSTR;
          end
        end
        OCC_HEAD: begin
          if (con && acc) begin
            head_pc_d    = if_pc;
            head_instr_d = if_instr;
          end else if (con) begin
            head_valid_d = 1'b0;
            head_instr_d = NOP_INSTR;
          end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = if_pc;
            skid_instr_d = if_instr;
          end else begin
            head_valid_d = head_valid_q;
          end
        end
        OCC_FULL: begin
          // if_ready is low here, so nothing new can arrive; skid drains first.
          if (con) begin
            head_pc_d    = skid_pc_q;
            head_instr_d = skid_instr_q;
            skid_valid_d = 1'b0;
          end else begin
            skid_valid_d = skid_valid_q;
          end
        end
        default: begin
          // Skid valid without head cannot happen; recover to empty.
          head_valid_d = 1'b0;
          head_instr_d = NOP_INSTR;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Head/skid registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid_q <= 1'b0;
      head_pc_q    <= '0;
      head_instr_q <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      head_valid_q <= head_valid_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  // An invalid head always holds NOP_INSTR, so the register drives decode directly.
  assign id_valid = head_valid_q;
  assign id_pc    = head_pc_q;
  assign id_instr = head_instr_q;

  instr_field_slicer u_slicer (
    .instr_i  (head_instr_q),
    .opcode_o (id_opcode),
    .rd_o     (id_rd),
    .rs1_o    (id_rs1),
    .rs2_o    (id_rs2),
    .funct3_o (id_funct3),
    .funct7_o (id_funct7),
    .iimm_o   (id_iimm),
    .simm_o   (id_simm),
    .bimm_o   (id_bimm),
    .uimm_o   (id_uimm),
    .jimm_o   (id_jimm)
  );

`ifdef IFID_ILLEGAL_CHK_EN
  logic illegal_q;

  // Illegal-opcode flag registered alongside the head entry it describes
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= head_valid_d & ~is_rv32i_opcode(head_instr_d[6:0]);
    end
  end

  assign id_illegal = illegal_q;
`else
  // Illegal-opcode check not built.
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios followed by random
// traffic, compared against a queue-based model of a 2-deep in-order buffer.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, id_ready;
  logic [31:0] if_pc, if_instr;
  logic        if_ready, id_valid;
  logic [31:0] id_pc, id_instr;
  logic [6:0]  id_opcode, id_funct7;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic [2:0]  id_funct3;
  logic [11:0] id_iimm, id_simm, id_bimm;
  logic [19:0] id_uimm, id_jimm;
`ifdef IFID_ILLEGAL_CHK_EN
  logic        id_illegal;
`endif

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Model: queue of {pc, instr} in program order, plus last head PC
  logic [63:0] mq[$];
  logic [31:0] last_pc;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_ready(if_ready), .flush(flush), .id_ready(id_ready), .id_valid(id_valid),
    .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_iimm(id_iimm), .id_simm(id_simm), .id_bimm(id_bimm), .id_uimm(id_uimm),
    .id_jimm(id_jimm)
`ifdef IFID_ILLEGAL_CHK_EN
    , .id_illegal(id_illegal)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic legal_op(input logic [6:0] op);
    return op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                      7'h13, 7'h33, 7'h0F, 7'h73};
  endfunction

  // Compare every output against the model's current state
  task automatic check_all();
    logic        ev;
    logic [31:0] ei;
    ev = (mq.size() > 0);
    ei = ev ? mq[0][31:0] : NOP;
    chk("id_valid", {31'd0, id_valid}, {31'd0, ev});
    chk("if_ready", {31'd0, if_ready}, {31'd0, (mq.size() < 2)});
    chk("id_pc", id_pc, last_pc);
    chk("id_instr", id_instr, ei);
    chk("opcode", {25'd0, id_opcode}, {25'd0, ei[6:0]});
    chk("rd",  {27'd0, id_rd},  {27'd0, ei[11:7]});
    chk("rs1", {27'd0, id_rs1}, {27'd0, ei[19:15]});
    chk("rs2", {27'd0, id_rs2}, {27'd0, ei[24:20]});
    chk("funct3", {29'd0, id_funct3}, {29'd0, ei[14:12]});
    chk("funct7", {25'd0, id_funct7}, {25'd0, ei[31:25]});
    chk("iimm", {20'd0, id_iimm}, {20'd0, ei[31:20]});
    chk("simm", {20'd0, id_simm}, {20'd0, ei[31:25], ei[11:7]});
    chk("bimm", {20'd0, id_bimm}, {20'd0, ei[31], ei[7], ei[30:25], ei[11:8]});
    chk("uimm", {12'd0, id_uimm}, {12'd0, ei[31:12]});
    chk("jimm", {12'd0, id_jimm}, {12'd0, ei[31:12]});
`ifdef IFID_ILLEGAL_CHK_EN
    chk("illegal", {31'd0, id_illegal}, {31'd0, (ev && !legal_op(ei[6:0]))});
`endif
  endtask

  // One clock: advance the model with the inputs seen at the edge, then check
  task automatic tick();
    logic acc, con;
    int   n;
    @(posedge clk);
    n = mq.size();
    if (rst) begin
      mq.delete();
      last_pc = 32'd0;
    end else if (flush) begin
      mq.delete();
    end else begin
      acc = if_valid && (n < 2);
      con = (n > 0) && id_ready;
      if (con) mq.delete(0);
      if (acc) mq.push_back({if_pc, if_instr});
    end
    if (mq.size() > 0) last_pc = mq[0][63:32];
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    if_valid = v; if_pc = pc; if_instr = ins; id_ready = rdy; flush = fl;
  endtask

  initial begin
    logic [31:0] ri;
    last_pc = 32'd0;
    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'h0000_0013);
    chk("rst_iimm", {20'd0, id_iimm}, 32'd0);
    chk("rst_ready", {31'd0, if_ready}, 32'd1);
    chk("rst_pc", id_pc, 32'd0);

    // Back-to-back stream with decode always ready
    drive(1'b1, 32'h0, 32'h0010_0093, 1'b1, 1'b0); tick();
    chk("s0_pc", id_pc, 32'h0);
    drive(1'b1, 32'h4, 32'h0020_0113, 1'b1, 1'b0); tick();
    chk("s1_pc", id_pc, 32'h4);
    chk("s1_rdy", {31'd0, if_ready}, 32'd1);
    drive(1'b1, 32'h8, 32'h0030_0193, 1'b1, 1'b0); tick();
    chk("s2_pc", id_pc, 32'h8);
    chk("s2_valid", {31'd0, id_valid}, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick();

    // Branch with negative offset
    drive(1'b1, 32'h30, 32'hFE01_0EE3, 1'b1, 1'b0); tick();
    chk("beq_bimm", {20'd0, id_bimm}, 32'h0000_0FFE);
    chk("beq_simm", {20'd0, id_simm}, 32'h0000_0FFD);
    chk("beq_rs1", {27'd0, id_rs1}, 32'd2);
    chk("beq_rs2", {27'd0, id_rs2}, 32'd0);
    // JAL
    drive(1'b1, 32'h34, 32'h8000_00EF, 1'b1, 1'b0); tick();
    chk("jal_jimm", {12'd0, id_jimm}, 32'h0008_0000);
    chk("jal_rd", {27'd0, id_rd}, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick();

    // Stall: head holds 0x10, skid takes 0x14, 0x18 waits
    drive(1'b1, 32'h10, 32'h0040_0213, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h14, 32'h0050_0293, 1'b0, 1'b0); tick();
    chk("stall_rdy", {31'd0, if_ready}, 32'd0);
    chk("stall_pc0", id_pc, 32'h10);
    drive(1'b1, 32'h18, 32'h0060_0313, 1'b0, 1'b0); tick();
    chk("stall_pc1", id_pc, 32'h10);
    drive(1'b1, 32'h18, 32'h0060_0313, 1'b1, 1'b0); tick();
    chk("rel_pc14", id_pc, 32'h14);
    chk("rel_rdy", {31'd0, if_ready}, 32'd1);
    tick();
    chk("rel_pc18", id_pc, 32'h18);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick();
    chk("rel_empty", {31'd0, id_valid}, 32'd0);

    // Flush with full buffer and an incoming offer
    drive(1'b1, 32'h40, 32'h0070_0393, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h44, 32'h0080_0413, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h20, 32'h0090_0493, 1'b0, 1'b1); tick();
    chk("fl_valid", {31'd0, id_valid}, 32'd0);
    chk("fl_rdy", {31'd0, if_ready}, 32'd1);
    chk("fl_instr", id_instr, 32'h0000_0013);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick();
    chk("fl_gone", {31'd0, id_valid}, 32'd0);

`ifdef IFID_ILLEGAL_CHK_EN
    drive(1'b1, 32'h50, 32'h0000_0000, 1'b1, 1'b0); tick();
    chk("ill_zero", {31'd0, id_illegal}, 32'd1);
    drive(1'b1, 32'h54, 32'h0000_0013, 1'b1, 1'b0); tick();
    chk("ill_nop", {31'd0, id_illegal}, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick();
`endif

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      ri = $urandom;
      if ($urandom_range(0, 1) == 0) ri[1:0] = 2'b11;
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, ri,
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
